// File: rtl/fpdivsqrt_share_pkg.sv
// ============================================================================
// Module   : fpdivsqrt_share_pkg
// Desc     : Shared types for the FP div/sqrt sharing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpdivsqrt_share_pkg;

  localparam int         c_TAG_W   = 5;
  localparam logic [1:0] c_FMT_F32 = 2'd0;
  localparam logic [1:0] c_FMT_F64 = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]         fmt;
    logic               is_fdiv;
    logic [63:0]        opa;
    logic [63:0]        opb;
    logic [2:0]         rm;
    logic [c_TAG_W-1:0] tag;
  } fu_req_t;

endpackage

`default_nettype wire

// File: rtl/fpdivsqrt_share_ctrl_if.sv
// ============================================================================
// Module   : fpdivsqrt_share_ctrl_if
// Desc     : Requester, unit and response buses of the div/sqrt sharing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpdivsqrt_share_ctrl_if
  import fpdivsqrt_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = c_TAG_W
);

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][1:0]        req_fmt_i;
  logic [NUM_REQ-1:0]             req_is_fdiv_i;
  logic [NUM_REQ-1:0][63:0]       req_opa_i;
  logic [NUM_REQ-1:0][63:0]       req_opb_i;
  logic [NUM_REQ-1:0][2:0]        req_rm_i;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i;
  logic [NUM_REQ-1:0]             flush_i;

  logic                           fu_start_valid_o;
  logic                           fu_start_ready_i;
  logic [1:0]                     fu_fmt_o;
  logic                           fu_is_fdiv_o;
  logic [63:0]                    fu_opa_o;
  logic [63:0]                    fu_opb_o;
  logic [2:0]                     fu_rm_o;
  logic                           fu_flush_o;
  logic                           fu_finish_valid_i;
  logic                           fu_finish_ready_o;
  logic [63:0]                    fu_res_i;
  logic [4:0]                     fu_fflags_i;

  logic [NUM_REQ-1:0]             rsp_valid_o;
  logic [NUM_REQ-1:0]             rsp_ready_i;
  logic [63:0]                    rsp_res_o;
  logic [4:0]                     rsp_fflags_o;
  logic [TAG_W-1:0]               rsp_tag_o;

  modport slave (
    input  req_valid_i, req_fmt_i, req_is_fdiv_i, req_opa_i, req_opb_i, req_rm_i,
           req_tag_i, flush_i, fu_start_ready_i, fu_finish_valid_i, fu_res_i,
           fu_fflags_i, rsp_ready_i,
    output req_ready_o, fu_start_valid_o, fu_fmt_o, fu_is_fdiv_o, fu_opa_o, fu_opb_o,
           fu_rm_o, fu_flush_o, fu_finish_ready_o, rsp_valid_o, rsp_res_o,
           rsp_fflags_o, rsp_tag_o
  );

  modport master (
    output req_valid_i, req_fmt_i, req_is_fdiv_i, req_opa_i, req_opb_i, req_rm_i,
           req_tag_i, flush_i, fu_start_ready_i, fu_finish_valid_i, fu_res_i,
           fu_fflags_i, rsp_ready_i,
    input  req_ready_o, fu_start_valid_o, fu_fmt_o, fu_is_fdiv_o, fu_opa_o, fu_opb_o,
           fu_rm_o, fu_flush_o, fu_finish_ready_o, rsp_valid_o, rsp_res_o,
           rsp_fflags_o, rsp_tag_o
  );

endinterface

`default_nettype wire

// File: rtl/fpdivsqrt_rr_arb.sv
// ============================================================================
// Module   : fpdivsqrt_rr_arb
// Desc     : Round-robin arbiter; pointer moves to winner+1 on advance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpdivsqrt_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  int               w_cand;

  // Scan from the farthest offset down so the nearest request at/after r_ptr wins.
  always_comb begin
    o_grant_idx = r_ptr;
    w_cand      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_cand = (int'(r_ptr) + off) % NUM_REQ;
      if (i_req[IDX_W'(w_cand)]) o_grant_idx = IDX_W'(w_cand);
    end
    o_grant = '0;
    if (|i_req) o_grant[o_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpdivsqrt_share_ctrl.sv
// ============================================================================
// Module   : fpdivsqrt_share_ctrl
// Desc     : Shares one FP div/sqrt unit among NUM_REQ requesters (round robin).
//            Optional FPDIVSQRT_SHARE_STATS_EN adds busy/op counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpdivsqrt_share_ctrl
  import fpdivsqrt_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = c_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fpdivsqrt_share_ctrl_if.slave      bus
`ifdef FPDIVSQRT_SHARE_STATS_EN
  ,
  output logic [31:0]                stat_busy_o,
  output logic [NUM_REQ-1:0][15:0]   stat_ops_o
`endif
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [c_IDX_W-1:0]   r_owner;
  fu_req_t              r_req;
  logic [63:0]          r_res;
  logic [4:0]           r_fflags;
  logic [TAG_W-1:0]     r_rsp_tag;

  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [c_IDX_W-1:0]   w_grant_idx;
  logic                 w_advance;
  logic                 w_capture;
  logic                 w_deliver;
  logic                 w_own_flush;

  assign w_elig      = bus.req_valid_i & ~bus.flush_i;
  assign w_own_flush = bus.flush_i[r_owner];

  fpdivsqrt_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (w_elig),
    .i_advance   (w_advance),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // An owner flush always wins: it suppresses start, finish capture and response.
  always_comb begin
    w_state_nxt           = r_state;
    w_advance             = 1'b0;
    w_capture             = 1'b0;
    w_deliver             = 1'b0;
    bus.req_ready_o       = '0;
    bus.fu_start_valid_o  = 1'b0;
    bus.fu_finish_ready_o = 1'b0;
    bus.fu_flush_o        = 1'b0;
    bus.rsp_valid_o       = '0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready_o = w_grant;
        if (|w_elig) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_own_flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          bus.fu_start_valid_o = 1'b1;
          if (bus.fu_start_ready_i) w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        bus.fu_finish_ready_o = 1'b1;
        if (w_own_flush) begin
          bus.fu_flush_o = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if (bus.fu_finish_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_own_flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          bus.rsp_valid_o[r_owner] = 1'b1;
          if (bus.rsp_ready_i[r_owner]) begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_req     <= '0;
      r_res     <= '0;
      r_fflags  <= '0;
      r_rsp_tag <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_owner       <= w_grant_idx;
        r_req.fmt     <= bus.req_fmt_i[w_grant_idx];
        r_req.is_fdiv <= bus.req_is_fdiv_i[w_grant_idx];
        r_req.opa     <= bus.req_opa_i[w_grant_idx];
        r_req.opb     <= bus.req_opb_i[w_grant_idx];
        r_req.rm      <= bus.req_rm_i[w_grant_idx];
        r_req.tag     <= bus.req_tag_i[w_grant_idx];
      end
      // Response tag is taken with the result so the bus holds until the next result.
      if (w_capture) begin
        r_res     <= bus.fu_res_i;
        r_fflags  <= bus.fu_fflags_i;
        r_rsp_tag <= r_req.tag;
      end
    end
  end

  assign bus.fu_fmt_o     = r_req.fmt;
  assign bus.fu_is_fdiv_o = r_req.is_fdiv;
  assign bus.fu_opa_o     = r_req.opa;
  assign bus.fu_opb_o     = r_req.opb;
  assign bus.fu_rm_o      = r_req.rm;
  assign bus.rsp_res_o    = r_res;
  assign bus.rsp_fflags_o = r_fflags;
  assign bus.rsp_tag_o    = r_rsp_tag;

`ifdef FPDIVSQRT_SHARE_STATS_EN
  logic [31:0]              r_stat_busy;
  logic [NUM_REQ-1:0][15:0] r_stat_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_busy <= '0;
    end else if ((r_state != ST_IDLE) && (r_stat_busy != '1)) begin
      r_stat_busy <= r_stat_busy + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_ops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stat_ops[gi] <= '0;
      end else if (w_deliver && (r_owner == c_IDX_W'(gi)) && (r_stat_ops[gi] != '1)) begin
        r_stat_ops[gi] <= r_stat_ops[gi] + 16'd1;
      end
    end
  end

  assign stat_busy_o = r_stat_busy;
  assign stat_ops_o  = r_stat_ops;
`endif

endmodule

`default_nettype wire
